ir_calc_core: RTL and testbench

//  Parametrised IR-keypad calculator core. Consumes decoded remote key codes, builds two

---
 rtl/ir_calc_core_if.sv | 35 +++
 rtl/ir_calc_core.sv | 202 ++++++++++++++++++++
 tb/tb_ir_calc_core.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ir_calc_core_if.sv
// ir_calc_core_if
//  Key/result bus between the IR key decoder, the calculator core and the
//  7-segment display path.
//  Signals:
//   key_valid  one-cycle strobe, key_code is valid
//   key_code   decoded key; 8'h00..8'h09 are digits 0..9
//   opa, opb   operands A and B (binary, OPW bits)
//   res_bcd    |result| in BCD, least-significant digit in [3:0]
//   res_neg    result sign (1 = negative)
//   res_valid  one-cycle pulse when res_bcd/res_neg are updated
//   busy       high while the core is calculating or converting
//  Modports: master = key source / result consumer, slave = calculator core.
interface ir_calc_core_if #(
    parameter int DIGITS = 2,
    parameter int OPW    = 7
);
    logic                      key_valid;
    logic [7:0]                key_code;
    logic [OPW-1:0]            opa;
    logic [OPW-1:0]            opb;
    logic [4*(DIGITS+1)-1:0]   res_bcd;
    logic                      res_neg;
    logic                      res_valid;
    logic                      busy;

    modport master (
        output key_valid, key_code,
        input  opa, opb, res_bcd, res_neg, res_valid, busy
    );

    modport slave (
        input  key_valid, key_code,
        output opa, opb, res_bcd, res_neg, res_valid, busy
    );
endinterface

// File: rtl/ir_calc_core.sv
// ir_calc_core
//  IR-keypad calculator core. Builds two decimal operands from key codes,
//  computes A+B or A-B on '=', and converts the signed result to BCD with a
//  sequential double-dabble engine (one result bit per cycle).
//  Ports:
//   CLOCK_50  system clock, rising edge
//   RST_N     asynchronous active-low reset
//   bus       ir_calc_core_if.slave: key strobe/code in, operands, BCD result,
//             sign, result-valid pulse and busy out
module ir_calc_core #(
    parameter int         DIGITS  = 2,
    parameter int         OPW     = 7,
    parameter logic [7:0] KEY_ADD = 8'h1A,
    parameter logic [7:0] KEY_SUB = 8'h1E,
    parameter logic [7:0] KEY_EQ  = 8'h12,
    parameter logic [7:0] KEY_CLR = 8'h0F
) (
    input  logic          CLOCK_50,
    input  logic          RST_N,
    ir_calc_core_if.slave bus
);
    localparam int RW   = OPW + 1;              // result width (sum carry)
    localparam int BW   = 4 * (DIGITS + 1);     // BCD result width
    localparam int CW   = $clog2(DIGITS + 1);   // digit counter width
    localparam int BCW  = $clog2(RW + 1);       // conversion bit counter width
    localparam int MAXV = 10 ** DIGITS - 1;     // largest enterable operand

    typedef enum logic [2:0] {
        ST_ENT_A,
        ST_ENT_B,
        ST_CALC,
        ST_CONV,
        ST_SHOW
    } state_t;

    state_t          state_q;
    logic [OPW-1:0]  opa_q, opb_q;
    logic [CW-1:0]   cnt_q;
    logic            sub_q;
    logic [RW-1:0]   r_q;        // last computed magnitude, kept for chaining
    logic            calc_neg_q; // sign of r_q, published when conversion ends
    logic [RW-1:0]   sr_q;       // magnitude bits still to be shifted in
    logic [BW-1:0]   dd_acc_q;   // double-dabble BCD accumulator
    logic [BCW-1:0]  bit_q;
    logic [BW-1:0]   res_bcd_q;
    logic            res_neg_q;
    logic            res_valid_q;
    logic            busy_q;

    // Key decode
    logic            is_digit, is_add, is_sub, is_eq, is_clr, is_op;
    logic [3:0]      digit;
    logic            cnt_full;
    logic [OPW-1:0]  opa_dig_d, opb_dig_d;

    always_comb begin
        is_digit  = bus.key_valid && (bus.key_code <= 8'h09);
        is_add    = bus.key_valid && (bus.key_code == KEY_ADD);
        is_sub    = bus.key_valid && (bus.key_code == KEY_SUB);
        is_eq     = bus.key_valid && (bus.key_code == KEY_EQ);
        is_clr    = bus.key_valid && (bus.key_code == KEY_CLR);
        is_op     = is_add || is_sub;
        digit     = bus.key_code[3:0];
        cnt_full  = (cnt_q == CW'(DIGITS));
        // Count limit guarantees these never overflow OPW bits.
        opa_dig_d = opa_q * OPW'(10) + OPW'(digit);
        opb_dig_d = opb_q * OPW'(10) + OPW'(digit);
    end

    // Arithmetic: magnitude and sign of the result
    logic [RW-1:0]   calc_r_d;
    logic            calc_neg_d;

    always_comb begin
        calc_neg_d = 1'b0;
        if (!sub_q) begin
            calc_r_d = RW'(opa_q) + RW'(opb_q);
        end else if (opa_q >= opb_q) begin
            calc_r_d = RW'(opa_q) - RW'(opb_q);
        end else begin
            calc_r_d   = RW'(opb_q) - RW'(opa_q);
            calc_neg_d = 1'b1;
        end
    end

    // Double-dabble step: add 3 to every BCD nibble >= 5, then shift in the
    // next magnitude bit (MSB first).
    logic [BW-1:0]   dd_adj;
    logic [BW-1:0]   dd_shift_d;

    generate
        for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_dd
            assign dd_adj[4*gi +: 4] = (dd_acc_q[4*gi +: 4] >= 4'd5)
                                     ? dd_acc_q[4*gi +: 4] + 4'd3
                                     : dd_acc_q[4*gi +: 4];
        end
    endgenerate

    assign dd_shift_d = {dd_adj[BW-2:0], sr_q[RW-1]};

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_ENT_A;
            opa_q       <= '0;
            opb_q       <= '0;
            cnt_q       <= '0;
            sub_q       <= 1'b0;
            r_q         <= '0;
            calc_neg_q  <= 1'b0;
            sr_q        <= '0;
            dd_acc_q    <= '0;
            bit_q       <= '0;
            res_bcd_q   <= '0;
            res_neg_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            if (is_clr) begin
                // Clear wins in every state, including an in-flight conversion.
                state_q   <= ST_ENT_A;
                opa_q     <= '0;
                opb_q     <= '0;
                cnt_q     <= '0;
                sub_q     <= 1'b0;
                res_bcd_q <= '0;
                res_neg_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_ENT_A: begin
                        if (is_digit && !cnt_full) begin
                            opa_q <= opa_dig_d;
                            cnt_q <= cnt_q + 1'b1;
                        end else if (is_op) begin
                            sub_q   <= is_sub;
                            cnt_q   <= '0;
                            state_q <= ST_ENT_B;
                        end
                    end
                    ST_ENT_B: begin
                        if (is_digit && !cnt_full) begin
                            opb_q <= opb_dig_d;
                            cnt_q <= cnt_q + 1'b1;
                        end else if (is_op) begin
                            sub_q <= is_sub;
                        end else if (is_eq) begin
                            busy_q  <= 1'b1;
                            state_q <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        r_q        <= calc_r_d;
                        calc_neg_q <= calc_neg_d;
                        sr_q       <= calc_r_d;
                        dd_acc_q   <= '0;
                        bit_q      <= '0;
                        state_q    <= ST_CONV;
                    end
                    ST_CONV: begin
                        dd_acc_q <= dd_shift_d;
                        sr_q     <= {sr_q[RW-2:0], 1'b0};
                        if (bit_q == BCW'(OPW)) begin
                            // Last bit: publish magnitude and sign together.
                            res_bcd_q   <= dd_shift_d;
                            res_neg_q   <= calc_neg_q;
                            res_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_SHOW;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        if (is_digit) begin
                            opa_q   <= OPW'(digit);
                            opb_q   <= '0;
                            cnt_q   <= CW'(1);
                            state_q <= ST_ENT_A;
                        end else if (is_op && !res_neg_q && (r_q <= RW'(MAXV))) begin
                            // Chain: a non-negative result that fits an operand
                            // becomes A of the next calculation.
                            opa_q   <= r_q[OPW-1:0];
                            opb_q   <= '0;
                            sub_q   <= is_sub;
                            cnt_q   <= '0;
                            state_q <= ST_ENT_B;
                        end
                    end
                    default: state_q <= ST_ENT_A;
                endcase
            end
        end
    end

    assign bus.opa       = opa_q;
    assign bus.opb       = opb_q;
    assign bus.res_bcd   = res_bcd_q;
    assign bus.res_neg   = res_neg_q;
    assign bus.res_valid = res_valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ir_calc_core.sv
module tb_ir_calc_core;
    localparam int         DIGITS  = 2;
    localparam int         OPW     = 7;
    localparam int         BW      = 4 * (DIGITS + 1);
    localparam int         MAXV    = 10 ** DIGITS - 1;
    localparam logic [7:0] KEY_ADD = 8'h1A;
    localparam logic [7:0] KEY_SUB = 8'h1E;
    localparam logic [7:0] KEY_EQ  = 8'h12;
    localparam logic [7:0] KEY_CLR = 8'h0F;

    localparam int PH_A = 0, PH_B = 1, PH_BUSY = 2, PH_SHOW = 3;

    logic CLOCK_50 = 1'b0;
    logic RST_N    = 1'b0;

    ir_calc_core_if #(.DIGITS(DIGITS), .OPW(OPW)) bus ();

    ir_calc_core #(
        .DIGITS(DIGITS), .OPW(OPW),
        .KEY_ADD(KEY_ADD), .KEY_SUB(KEY_SUB), .KEY_EQ(KEY_EQ), .KEY_CLR(KEY_CLR)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RST_N   (RST_N),
        .bus     (bus.slave)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int key_edge = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS + 1; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // ---------------- behavioural reference model ----------------
    int        m_phase, m_a, m_b, m_cnt, m_left, m_r;
    bit        m_sub, m_pneg, m_neg, m_valid;
    logic [BW-1:0] m_bcd;

    wire       kv = bus.key_valid;
    wire [7:0] kc = bus.key_code;

    always @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            m_phase <= PH_A; m_a <= 0; m_b <= 0; m_cnt <= 0; m_left <= 0; m_r <= 0;
            m_sub <= 0; m_pneg <= 0; m_neg <= 0; m_valid <= 0; m_bcd <= '0;
        end else begin
            m_valid <= 0;
            if (kv && kc == KEY_CLR) begin
                m_phase <= PH_A; m_a <= 0; m_b <= 0; m_cnt <= 0; m_sub <= 0;
                m_bcd <= '0; m_neg <= 0; m_left <= 0;
            end else if (m_phase == PH_A) begin
                if (kv && kc <= 8'd9) begin
                    if (m_cnt < DIGITS) begin
                        m_a <= m_a * 10 + int'(kc);
                        m_cnt <= m_cnt + 1;
                    end
                end else if (kv && (kc == KEY_ADD || kc == KEY_SUB)) begin
                    m_sub <= (kc == KEY_SUB); m_cnt <= 0; m_phase <= PH_B;
                end
            end else if (m_phase == PH_B) begin
                if (kv && kc <= 8'd9) begin
                    if (m_cnt < DIGITS) begin
                        m_b <= m_b * 10 + int'(kc);
                        m_cnt <= m_cnt + 1;
                    end
                end else if (kv && (kc == KEY_ADD || kc == KEY_SUB)) begin
                    m_sub <= (kc == KEY_SUB);
                end else if (kv && kc == KEY_EQ) begin
                    // Result appears OPW+2 edges after the EQ edge.
                    m_phase <= PH_BUSY;
                    m_left  <= OPW + 2;
                    if (!m_sub)          begin m_r <= m_a + m_b; m_pneg <= 0; end
                    else if (m_a >= m_b) begin m_r <= m_a - m_b; m_pneg <= 0; end
                    else                 begin m_r <= m_b - m_a; m_pneg <= 1; end
                end
            end else if (m_phase == PH_BUSY) begin
                if (m_left == 1) begin
                    m_bcd <= to_bcd(m_r); m_neg <= m_pneg; m_valid <= 1;
                    m_phase <= PH_SHOW; m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                end
            end else begin
                if (kv && kc <= 8'd9) begin
                    m_a <= int'(kc); m_b <= 0; m_cnt <= 1; m_phase <= PH_A;
                end else if (kv && (kc == KEY_ADD || kc == KEY_SUB) && !m_neg && m_r <= MAXV) begin
                    m_a <= m_r; m_b <= 0; m_sub <= (kc == KEY_SUB); m_cnt <= 0; m_phase <= PH_B;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge CLOCK_50) begin
        if (RST_N) begin
            chk("opa",       bus.opa,       m_a);
            chk("opb",       bus.opb,       m_b);
            chk("res_bcd",   bus.res_bcd,   m_bcd);
            chk("res_neg",   bus.res_neg,   m_neg);
            chk("res_valid", bus.res_valid, m_valid);
            chk("busy",      bus.busy,      m_phase == PH_BUSY);
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [7:0] c);
        @(negedge CLOCK_50);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(negedge CLOCK_50);
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        key_edge = cyc;
        $display("key %02h sampled at cycle %0d", c, key_edge);
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            if (bus.res_valid) begin
                lat = cyc - key_edge;
                break;
            end
        end
        chk("res_valid_seen", lat >= 0, 1);
        $display("result bcd=%03h neg=%0d latency=%0d", bus.res_bcd, bus.res_neg, lat);
    endtask

    initial begin
        int lat;
        bit seen;
        logic [7:0] k;
        int sel;

        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;

        // Reset state
        #12;
        chk("rst_opa", bus.opa, 0);
        chk("rst_opb", bus.opb, 0);
        chk("rst_bcd", bus.res_bcd, 0);
        chk("rst_neg", bus.res_neg, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_busy", bus.busy, 0);
        @(negedge CLOCK_50);
        RST_N = 1'b1;

        // 1: 12 + 34 = 46, latency OPW+2 = 9
        press(8'h01); press(8'h02); press(KEY_ADD); press(8'h03); press(8'h04);
        chk("t1_opa", bus.opa, 12);
        chk("t1_opb", bus.opb, 34);
        press(KEY_EQ);
        chk("t1_busy", bus.busy, 1);
        wait_valid(lat);
        chk("t1_latency", lat, 9);
        chk("t1_bcd", bus.res_bcd, 12'h046);
        chk("t1_neg", bus.res_neg, 0);

        // 2: 5 - 20 = -15
        press(8'h05); press(KEY_SUB); press(8'h02); press(8'h00); press(KEY_EQ);
        wait_valid(lat);
        chk("t2_bcd", bus.res_bcd, 12'h015);
        chk("t2_neg", bus.res_neg, 1);

        // 3: 99 + 99 = 198; then third digit ignored
        press(8'h09); press(8'h09); press(KEY_ADD); press(8'h09); press(8'h09); press(KEY_EQ);
        wait_valid(lat);
        chk("t3_bcd", bus.res_bcd, 12'h198);
        press(8'h01); press(8'h02); press(8'h03);
        chk("t3_opa", bus.opa, 12);

        // 4: CLR aborts a conversion
        press(KEY_ADD); press(8'h02); press(KEY_EQ);
        repeat (3) @(negedge CLOCK_50);
        chk("t4_busy_mid", bus.busy, 1);
        press(KEY_CLR);
        chk("t4_bcd", bus.res_bcd, 0);
        chk("t4_opa", bus.opa, 0);
        chk("t4_opb", bus.opb, 0);
        chk("t4_busy", bus.busy, 0);
        chk("t4_valid", bus.res_valid, 0);
        seen = 0;
        repeat (12) begin
            @(negedge CLOCK_50);
            if (bus.res_valid) seen = 1;
        end
        chk("t4_no_valid", seen, 0);

        // 5: chaining
        press(8'h05); press(8'h00); press(KEY_ADD); press(8'h01); press(KEY_EQ);
        wait_valid(lat);
        chk("t5_bcd_a", bus.res_bcd, 12'h051);
        press(KEY_ADD);
        chk("t5_chain_opa", bus.opa, 51);
        press(8'h09); press(KEY_EQ);
        wait_valid(lat);
        chk("t5_bcd_b", bus.res_bcd, 12'h060);
        press(8'h01); press(KEY_SUB); press(8'h02); press(KEY_EQ);
        wait_valid(lat);
        chk("t5_bcd_c", bus.res_bcd, 12'h001);
        chk("t5_neg_c", bus.res_neg, 1);
        press(KEY_ADD);
        chk("t5_ign_opa", bus.opa, 1);
        chk("t5_ign_opb", bus.opb, 2);
        chk("t5_ign_bcd", bus.res_bcd, 12'h001);

        // 6: asynchronous reset mid-entry
        press(KEY_CLR); press(8'h01); press(KEY_ADD); press(8'h03);
        chk("t6_opb", bus.opb, 3);
        @(posedge CLOCK_50);
        #2 RST_N = 1'b0;
        #1;
        chk("t6_opa", bus.opa, 0);
        chk("t6_opb0", bus.opb, 0);
        chk("t6_bcd", bus.res_bcd, 0);
        chk("t6_busy", bus.busy, 0);
        @(negedge CLOCK_50);
        RST_N = 1'b1;
        press(8'h04); press(KEY_ADD);
        chk("t6_opa4", bus.opa, 4);

        // Randomised key stream checked by the model every cycle
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 45)      k = 8'($urandom_range(0, 9));
            else if (sel < 58) k = KEY_ADD;
            else if (sel < 70) k = KEY_SUB;
            else if (sel < 85) k = KEY_EQ;
            else if (sel < 90) k = KEY_CLR;
            else begin
                k = 8'($urandom_range(10, 255));
                if (k == KEY_ADD || k == KEY_SUB || k == KEY_EQ || k == KEY_CLR) k = 8'h55;
            end
            press(k);
            repeat ($urandom_range(0, 12)) @(negedge CLOCK_50);
        end
        repeat (15) @(negedge CLOCK_50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
